reg_writeback_unit: RTL and testbench
=====================================

Name: reg_writeback_unit

Overview:
- Initiator side of the register file write port: accepts completed results from the execute/memory stages over a valid/ready handshake.
- Buffers results in a small FIFO, then drives write_reg/write_data/regWrite/byteOperations into register_block one write per cycle.
- Exposes a two-probe forwarding lookup so the decode stage can see values that are not yet written to the register file.

Parameters:
DATA_W, 32, data width of results and register file write data
ADDR_W, 5, register index width
DEPTH, 2, pending-result FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  result available
in_ready  output  1  unit can accept a result this cycle
in_reg  input  ADDR_W  destination register index
in_data  input  DATA_W  result value
in_byte  input  1  byte operation flag, forwarded as byteOperations
wb_stall  input  1  freeze draining to the register file
regWrite  output  1  register file write enable (registered)
write_reg  output  ADDR_W  register file write index (registered)
write_data  output  DATA_W  register file write data (registered)
byteOperations  output  1  register file byte-mode flag (registered)
probe_reg1  input  ADDR_W  forwarding lookup index 1
probe_reg2  input  ADDR_W  forwarding lookup index 2
fwd_hit1  output  1  pending write to probe_reg1 exists
fwd_data1  output  DATA_W  newest pending value for probe_reg1
fwd_hit2  output  1  pending write to probe_reg2 exists
fwd_data2  output  DATA_W  newest pending value for probe_reg2

Behaviour:
- Reset (async, rst_n=0): regWrite=0, write_reg=0, write_data=0, byteOperations=0; FIFO count=0, pointers=0; all pending entries are discarded, including after a mid-operation reset. regWrite falls immediately, without waiting for clk.
- in_ready = (count < DEPTH). It is combinational from registered count only and is 1 during and after reset.
- Accept: in_valid & in_ready at a rising edge.
  - An accept with in_reg==0 is consumed (the handshake completes) but nothing is queued and no write occurs.
- Write stage W = {regWrite, write_reg, write_data, byteOperations}, updated at each rising edge as follows:
  - If wb_stall=1: W holds all values, no pop; regWrite keeps its value, so the same write is re-presented (register file writes are idempotent).
  - Else if count>0: W loads the FIFO head, regWrite=1, pop.
  - Else if an accept with in_reg!=0 is occurring: W loads the incoming result directly (bypass, FIFO untouched), regWrite=1.
  - Else: regWrite=0; write_reg, write_data and byteOperations hold.
- Push: an accept with in_reg!=0 that is not taken by the bypass is written at the tail. Push and pop in the same edge are legal; count is unchanged.
- Latency: with the unit empty and not stalled, a result accepted at edge N is on the write port with regWrite=1 for the cycle following edge N. Results are written strictly in acceptance order.
- Throughput: 1 result/cycle sustained without stall. Under stall the FIFO fills to DEPTH, then in_ready=0.
- Forwarding (combinational):
  - Candidates: the FIFO valid entries, plus W when regWrite=1.
  - Priority, newest first: FIFO tail-1 down to head, then W.
  - fwd_hitN=1 if any candidate's reg equals probe_regN and probe_regN!=0. fwd_dataN is that candidate's raw data (no byte processing); 0 when there is no hit.
  - probe_regN==0 never hits.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- No X on any output after reset.

Test Plan:
- Reset then a single result: accept reg=14, data=0x55555557, byte=0 at edge 1 -> cycle after edge 1: regWrite=1, write_reg=14, write_data=0x55555557, byteOperations=0; next cycle regWrite=0.
- Register zero: accept reg=0, data=0xFFFFFFFF -> in_ready stays 1, regWrite never asserts, fwd_hit1=0 with probe_reg1=0.
- Stall fill: wb_stall=1, W holding reg 3; accept reg 5 then reg 6 -> count=2, in_ready=0, third in_valid is not accepted. Release stall -> writes to reg 5 then reg 6 on consecutive cycles, in_ready returns to 1.
- Forwarding priority: under stall, W={reg 7, 0x11}, FIFO holds reg 7=0x22 then reg 7=0x33; probe_reg1=7 -> fwd_hit1=1, fwd_data1=0x33; probe_reg2=8 -> fwd_hit2=0, fwd_data2=0.
- Back-to-back stream: accept regs 1,2,3,4 with data 0xA1..0xA4 on consecutive edges, no stall -> four consecutive regWrite=1 cycles in order; count never exceeds 0; byteOperations follows each in_byte.
- Async reset mid-operation: with 2 entries queued and regWrite=1, drop rst_n between edges -> regWrite=0 immediately, count=0, in_ready=1, no further writes after rst_n rises.

Source files
------------

// File: rtl/reg_writeback_unit.sv
// Register-file write-back unit.
// Accepts completed results over a valid/ready handshake and buffers them in a
// small FIFO. It drains them into the register file one write per cycle, and
// answers two forwarding lookups against every write that is still pending.
module reg_writeback_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_reg,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_byte,
    input  logic              wb_stall,
    output logic              regWrite,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              byteOperations,
    input  logic [ADDR_W-1:0] probe_reg1,
    input  logic [ADDR_W-1:0] probe_reg2,
    output logic              fwd_hit1,
    output logic [DATA_W-1:0] fwd_data1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data2
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Pending-result storage. It has no reset: count_reg alone decides which
    // slots are valid, so a reset discards every entry at once.
    logic [ADDR_W-1:0] mem_reg  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic              mem_byte [DEPTH];

    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [CNT_W-1:0]  count_reg;

    // Write stage W, which drives the register-file port directly.
    logic              w_valid_reg;
    logic [ADDR_W-1:0] w_reg_reg;
    logic [DATA_W-1:0] w_data_reg;
    logic              w_byte_reg;

    logic accept;
    logic accept_nz;
    logic pop;
    logic bypass;
    logic push;

    // Readiness depends only on the registered occupancy, never on in_valid.
    assign in_ready = (count_reg < DEPTH_C);

    // Handshake decode. Results for r0 are consumed but discarded. When the
    // FIFO is empty and the unit is not stalled, the incoming result skips
    // the FIFO and goes straight into W.
    always_comb begin
        accept    = in_valid & in_ready;
        accept_nz = accept & (in_reg != '0);
        pop       = ~wb_stall & (count_reg != '0);
        bypass    = ~wb_stall & (count_reg == '0) & accept_nz;
        push      = accept_nz & ~bypass;
    end

    // FIFO pointers, occupancy and the write stage. The reset is asynchronous,
    // so regWrite drops without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            w_valid_reg <= 1'b0;
            w_reg_reg   <= '0;
            w_data_reg  <= '0;
            w_byte_reg  <= 1'b0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
            // A stall freezes W entirely. A still-valid write is presented
            // again, which is harmless because register writes are idempotent.
            if (!wb_stall) begin
                if (pop) begin
                    w_valid_reg <= 1'b1;
                    w_reg_reg   <= mem_reg[head_reg];
                    w_data_reg  <= mem_data[head_reg];
                    w_byte_reg  <= mem_byte[head_reg];
                end else if (bypass) begin
                    w_valid_reg <= 1'b1;
                    w_reg_reg   <= in_reg;
                    w_data_reg  <= in_data;
                    w_byte_reg  <= in_byte;
                end else begin
                    w_valid_reg <= 1'b0;
                end
            end
        end
    end

    // Write the FIFO tail on every accepted result that the bypass does not take.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[tail_reg]  <= in_reg;
            mem_data[tail_reg] <= in_data;
            mem_byte[tail_reg] <= in_byte;
        end
    end

    assign regWrite       = w_valid_reg;
    assign write_reg      = w_reg_reg;
    assign write_data     = w_data_reg;
    assign byteOperations = w_byte_reg;

    // Forwarding lanes. Each lane searches from oldest to newest: W first, then
    // the FIFO from head to tail-1. A later match overrides an earlier one, so
    // the newest pending value wins.
    logic [ADDR_W-1:0] probe    [2];
    logic              hit      [2];
    logic [DATA_W-1:0] hit_data [2];

    assign probe[0] = probe_reg1;
    assign probe[1] = probe_reg2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic              hit_raw;
            logic [DATA_W-1:0] data_raw;
            logic [PTR_W-1:0]  idx;

            // Find the newest pending value for this probe. Register 0 never hits.
            always_comb begin
                hit_raw  = 1'b0;
                data_raw = '0;
                idx      = '0;
                if (w_valid_reg && (w_reg_reg == probe[gi])) begin
                    hit_raw  = 1'b1;
                    data_raw = w_data_reg;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    idx = head_reg + PTR_W'(i);
                    if ((CNT_W'(i) < count_reg) && (mem_reg[idx] == probe[gi])) begin
                        hit_raw  = 1'b1;
                        data_raw = mem_data[idx];
                    end
                end
                hit[gi]      = hit_raw && (probe[gi] != '0);
                hit_data[gi] = hit[gi] ? data_raw : '0;
            end
        end
    endgenerate

    assign fwd_hit1  = hit[0];
    assign fwd_data1 = hit_data[0];
    assign fwd_hit2  = hit[1];
    assign fwd_data2 = hit_data[1];

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Testbench for reg_writeback_unit.
// The driver keeps an abstract model of the unit: a list of results still
// waiting to reach the port, plus the result now on the port. The driver
// checks ready and forwarding against this model. Every accepted result is
// also placed on a scoreboard queue, and an independent monitor checks each
// completed register write against that queue.
module tb_reg_writeback_unit;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_reg = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_byte = 1'b0;
    logic          wb_stall = 1'b0;
    logic          regWrite;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic          byteOperations;
    logic [AW-1:0] probe_reg1 = '0;
    logic [AW-1:0] probe_reg2 = '0;
    logic          fwd_hit1;
    logic [DW-1:0] fwd_data1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data2;

    reg_writeback_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_data(in_data), .in_byte(in_byte),
        .wb_stall(wb_stall),
        .regWrite(regWrite), .write_reg(write_reg), .write_data(write_data),
        .byteOperations(byteOperations),
        .probe_reg1(probe_reg1), .probe_reg2(probe_reg2),
        .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
        .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
        logic          b;
    } res_t;

    res_t pend[$];      // accepted results that are not yet on the write port
    res_t exp_q[$];     // scoreboard: every write expected on the port, in order
    res_t w_model;
    bit   w_valid_model = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Search the pending list from newest to oldest, then the port itself.
    function automatic void model_fwd(input logic [AW-1:0] p, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (p == '0) return;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].r == p) begin
                hit = 1'b1;
                d   = pend[i].d;
                return;
            end
        end
        if (w_valid_model && w_model.r == p) begin
            hit = 1'b1;
            d   = w_model.d;
        end
    endfunction

    // A write completes when the port shows regWrite while not stalled.
    // Complete writes are checked against the scoreboard.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && regWrite === 1'b1 && wb_stall === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", {63'd0, regWrite}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("WRITE reg=%0d data=%08h byte=%0b", write_reg, write_data, byteOperations);
                    check("write_reg", 64'(write_reg), 64'(e.r));
                    check("write_data", 64'(write_data), 64'(e.d));
                    check("byteOperations", 64'(byteOperations), 64'(e.b));
                end
            end
        end
    end

    // Run one clock cycle. The task is entered 1 time unit after a rising edge.
    task automatic cycle(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                         input logic b, input logic s, input logic [AW-1:0] p1, input logic [AW-1:0] p2);
        logic          h;
        logic [DW-1:0] hd;
        res_t          n;
        bit            rdy;
        in_valid   = v;
        in_reg     = r;
        in_data    = d;
        in_byte    = b;
        wb_stall   = s;
        probe_reg1 = p1;
        probe_reg2 = p2;
        @(negedge clk);
        rdy = (pend.size() < DEPTH);
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("regWrite", 64'(regWrite), 64'(w_valid_model));
        model_fwd(p1, h, hd);
        check("fwd_hit1", 64'(fwd_hit1), 64'(h));
        check("fwd_data1", 64'(fwd_data1), 64'(hd));
        model_fwd(p2, h, hd);
        check("fwd_hit2", 64'(fwd_hit2), 64'(h));
        check("fwd_data2", 64'(fwd_data2), 64'(hd));
        if (v && rdy && r != '0) begin
            n.r = r;
            n.d = d;
            n.b = b;
            pend.push_back(n);
            exp_q.push_back(n);
        end
        @(posedge clk);
        if (!s) begin
            if (pend.size() > 0) begin
                w_model       = pend.pop_front();
                w_valid_model = 1'b1;
            end else begin
                w_valid_model = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state, checked while the reset is held.
        #17;
        check("rst_regWrite", 64'(regWrite), 64'd0);
        check("rst_write_reg", 64'(write_reg), 64'd0);
        check("rst_write_data", 64'(write_data), 64'd0);
        check("rst_byteOps", 64'(byteOperations), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // A single result, then the port goes idle.
        cycle(1'b1, 5'd14, 32'h5555_5557, 1'b0, 1'b0, 5'd14, 5'd0);
        idle(2);

        // A result for register 0 is consumed and never written.
        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 5'd0);
        idle(2);

        // Fill the FIFO under stall. The third offer is refused.
        cycle(1'b1, 5'd3, 32'h3333, 1'b0, 1'b0, 5'd3, 5'd0);
        cycle(1'b1, 5'd5, 32'h5555, 1'b1, 1'b1, 5'd3, 5'd5);
        cycle(1'b1, 5'd6, 32'h6666, 1'b0, 1'b1, 5'd5, 5'd6);
        cycle(1'b1, 5'd9, 32'h9999, 1'b0, 1'b1, 5'd6, 5'd9);
        idle(4);

        // Forwarding priority: the newest of three pending reg-7 values wins.
        cycle(1'b1, 5'd7, 32'h11, 1'b0, 1'b0, 5'd7, 5'd8);
        cycle(1'b1, 5'd7, 32'h22, 1'b0, 1'b1, 5'd7, 5'd8);
        cycle(1'b1, 5'd7, 32'h33, 1'b0, 1'b1, 5'd7, 5'd8);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7, 5'd8);
        idle(4);

        // Back-to-back stream with varying byte flags.
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, AW'(i), 32'hA0 + DW'(i), i[0], 1'b0, AW'(i), AW'(i - 1));
        end
        idle(3);

        // Assert reset asynchronously while writes are still pending.
        cycle(1'b1, 5'd10, 32'hAAAA, 1'b0, 1'b0, 5'd10, 5'd0);
        cycle(1'b1, 5'd11, 32'hBBBB, 1'b0, 1'b1, 5'd10, 5'd11);
        cycle(1'b1, 5'd12, 32'hCCCC, 1'b1, 1'b1, 5'd11, 5'd12);
        in_valid   = 1'b0;
        probe_reg1 = 5'd11;
        probe_reg2 = 5'd12;
        #2 rst_n = 1'b0;
        pend.delete();
        exp_q.delete();
        w_valid_model = 1'b0;
        #1;
        check("async_rst_regWrite", 64'(regWrite), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_fwd_hit1", 64'(fwd_hit1), 64'd0);
        check("async_rst_fwd_hit2", 64'(fwd_hit2), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);

        // Randomized traffic with stalls and narrow register indices, so
        // that forwarding hits are frequent.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, AW'($urandom_range(0, 7)), DW'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        idle(DEPTH + 3);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
